// File: rtl/aes_stream_arbiter_if.sv
// Bundle of requester, response and cipher-core pins for the stream arbiter.
// slave = arbiter side, master = requesters/core side.
interface aes_stream_arbiter_if #(
   parameter int N_CH = 4
);
   localparam int CW = $clog2(N_CH);

   logic [N_CH-1:0]   req_valid;
   logic [N_CH*8-1:0] req_data;
   logic [N_CH*8-1:0] req_key;
   logic [N_CH-1:0]   req_last;
   logic [N_CH-1:0]   req_ready;
   logic              resp_valid;
   logic [CW-1:0]     resp_ch;
   logic [7:0]        resp_data;
   logic              resp_last;
   logic              busy;
   logic              core_new_msg;
   logic [7:0]        core_key;
   logic              core_in_valid;
   logic [7:0]        core_in;
   logic [7:0]        core_out;

   modport slave (
      input  req_valid, req_data, req_key, req_last, core_out,
      output req_ready, resp_valid, resp_ch, resp_data, resp_last, busy,
             core_new_msg, core_key, core_in_valid, core_in
   );

   modport master (
      output req_valid, req_data, req_key, req_last, core_out,
      input  req_ready, resp_valid, resp_ch, resp_data, resp_last, busy,
             core_new_msg, core_key, core_in_valid, core_in
   );
endinterface

// File: rtl/aes_stream_arbiter.sv
// Round-robin, message-granular sharing of one byte cipher core between N_CH keyed channels.
//   state | meaning
//   IDLE  | no owner; pick next requester from rr_ptr
//   LOAD  | pulse core_new_msg with the owner's key
//   ISSUE | req_ready to owner, wait for its byte
//   PEND  | byte presented to core (core_in_valid)
//   WAIT  | count core latency, then capture and emit response
module aes_stream_arbiter #(
   parameter int N_CH     = 4,
   parameter int CORE_LAT = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   aes_stream_arbiter_if.slave bus
);
   localparam int CW    = $clog2(N_CH);
   localparam int CNT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, ISSUE, PEND, WAIT} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    rr_ptr, grant, pick;
   logic             pick_found, last_r, hs, done;
   logic [CNT_W-1:0] cnt;
   int               j;

   always_comb begin
      pick_found = 1'b0;
      pick       = rr_ptr;
      j          = 0;
      for (int i = 0; i < N_CH; i++) begin
         j = int'(rr_ptr) + i;
         if (j >= N_CH) j = j - N_CH;
         if (!pick_found && bus.req_valid[j]) begin
            pick_found = 1'b1;
            pick       = CW'(j);
         end
      end
   end

   assign hs   = (state == ISSUE) && bus.req_valid[grant];
   assign done = (state == WAIT) && (cnt == CNT_W'(CORE_LAT - 1));

   // Ready depends only on state/grant, never on req_valid.
   always_comb begin
      bus.req_ready = '0;
      if (state == ISSUE) bus.req_ready[grant] = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_found) state_nxt = LOAD;
         LOAD:    state_nxt = ISSUE;
         ISSUE:   if (hs) state_nxt = PEND;
         PEND:    state_nxt = WAIT;
         WAIT:    if (done) state_nxt = last_r ? IDLE : ISSUE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr            <= '0;
         grant             <= '0;
         last_r            <= 1'b0;
         cnt               <= '0;
         bus.busy          <= 1'b0;
         bus.resp_valid    <= 1'b0;
         bus.resp_ch       <= '0;
         bus.resp_data     <= '0;
         bus.resp_last     <= 1'b0;
         bus.core_new_msg  <= 1'b0;
         bus.core_key      <= '0;
         bus.core_in_valid <= 1'b0;
         bus.core_in       <= '0;
      end else begin
         bus.busy          <= (state_nxt != IDLE);
         bus.resp_valid    <= 1'b0;
         bus.core_new_msg  <= 1'b0;
         bus.core_key      <= '0;
         bus.core_in_valid <= 1'b0;
         bus.core_in       <= '0;
         case (state)
            IDLE: if (pick_found) begin
               grant            <= pick;
               bus.core_new_msg <= 1'b1;
               bus.core_key     <= bus.req_key[int'(pick)*8 +: 8];
            end
            ISSUE: if (hs) begin
               bus.core_in_valid <= 1'b1;
               bus.core_in       <= bus.req_data[int'(grant)*8 +: 8];
               last_r            <= bus.req_last[grant];
            end
            PEND: cnt <= '0;
            WAIT: begin
               cnt <= cnt + 1'b1;
               if (done) begin
                  bus.resp_valid <= 1'b1;
                  bus.resp_data  <= bus.core_out;
                  bus.resp_ch    <= grant;
                  bus.resp_last  <= last_r;
                  if (last_r) rr_ptr <= (grant == CW'(N_CH - 1)) ? '0 : grant + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_stream_arbiter.sv
// Directed bench for aes_stream_arbiter with a behavioural keyed XOR-stream core model.
module tb_aes_stream_arbiter;
   localparam int N_CH     = 4;
   localparam int CORE_LAT = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   aes_stream_arbiter_if #(.N_CH(N_CH)) bus ();
   aes_stream_arbiter #(.N_CH(N_CH), .CORE_LAT(CORE_LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] enc(input logic [7:0] key, input int idx, input logic [7:0] d);
      logic [7:0] i8;
      i8 = 8'(idx);
      return d ^ 8'(key + 8'(i8 * 8'h1D));
   endfunction

   // Core model: key and byte index reset on new_msg; result stable CORE_LAT edges after in_valid.
   logic [7:0] ck_key = 8'h00, ck_idx = 8'h00, ck_stage = 8'h00;
   always @(posedge clk) begin
      if (bus.core_new_msg) begin
         ck_key <= bus.core_key;
         ck_idx <= 8'h00;
      end
      if (bus.core_in_valid) begin
         ck_stage <= bus.core_in ^ 8'(ck_key + 8'(ck_idx * 8'h1D));
         ck_idx   <= ck_idx + 8'h01;
      end
      bus.core_out <= ck_stage;
   end

   typedef struct packed {logic [1:0] ch; logic [7:0] data; logic last;} resp_t;
   resp_t      rlog[128];
   logic [7:0] klog[32];
   int rcnt = 0, kcnt = 0, onehot_err = 0;

   always @(negedge clk) begin
      if (bus.resp_valid && rcnt < 128) begin
         rlog[rcnt] = '{ch: bus.resp_ch, data: bus.resp_data, last: bus.resp_last};
         rcnt++;
      end
      if (bus.core_new_msg && kcnt < 32) begin
         klog[kcnt] = bus.core_key;
         kcnt++;
      end
      if (!$onehot0(bus.req_ready)) onehot_err++;
   end

   // Per-channel byte FIFOs feeding the requester pins.
   logic [8:0] cm[N_CH][32];
   logic [7:0] ch_key[N_CH];
   int  ch_head[N_CH];
   int  ch_tail[N_CH];
   bit  hold[N_CH];

   initial begin
      bit fired[N_CH];
      bit pend[N_CH];
      logic [8:0] ent;
      for (int c = 0; c < N_CH; c++) begin
         pend[c] = 1'b0; ch_head[c] = 0;
      end
      bus.req_valid = '0; bus.req_data = '0; bus.req_key = '0; bus.req_last = '0;
      forever begin
         @(posedge clk);
         for (int c = 0; c < N_CH; c++) fired[c] = pend[c] && rst_n;
         @(negedge clk);
         for (int c = 0; c < N_CH; c++) begin
            if (fired[c]) ch_head[c]++;
            ent = cm[c][ch_head[c] % 32];
            bus.req_valid[c]       = (ch_head[c] != ch_tail[c]) && !hold[c];
            bus.req_data[c*8 +: 8] = ent[7:0];
            bus.req_last[c]        = bus.req_valid[c] & ent[8];
            bus.req_key[c*8 +: 8]  = ch_key[c];
         end
         for (int c = 0; c < N_CH; c++) pend[c] = bus.req_valid[c] && bus.req_ready[c];
      end
   end

   task automatic push(input int c, input logic [7:0] d, input logic l);
      cm[c][ch_tail[c] % 32] = {l, d};
      ch_tail[c]++;
   endtask

   task automatic flush_release();
      @(posedge clk);
      @(negedge clk);
      for (int c = 0; c < N_CH; c++) begin
         ch_tail[c] = ch_head[c];
         hold[c]    = 1'b0;
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      flush_release();
   endtask

   task automatic wait_resp(input int target, input string name);
      int k = 0;
      while (rcnt < target && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(rcnt >= target), 32'd1);
   endtask

   typedef struct {int ch; logic [7:0] key; logic [7:0] data; logic last; logic [7:0] exp;} rec_t;
   rec_t tab[13];

   initial begin
      int base, kb, bad;
      logic [7:0] ct[5];
      logic [7:0] pt[5];
      for (int c = 0; c < N_CH; c++) begin
         ch_tail[c] = 0; hold[c] = 1'b0; ch_key[c] = 8'h00;
      end
      // ch0 single 5-byte message, then four 2-byte messages in grant order.
      tab[0]  = '{0, 8'h2B, 8'h00, 1'b0, 8'h2B};
      tab[1]  = '{0, 8'h2B, 8'h01, 1'b0, 8'h49};
      tab[2]  = '{0, 8'h2B, 8'h02, 1'b0, 8'h67};
      tab[3]  = '{0, 8'h2B, 8'h03, 1'b0, 8'h81};
      tab[4]  = '{0, 8'h2B, 8'h04, 1'b1, 8'h9B};
      tab[5]  = '{0, 8'h11, 8'h10, 1'b0, 8'h01};
      tab[6]  = '{0, 8'h11, 8'h11, 1'b1, 8'h3F};
      tab[7]  = '{1, 8'h22, 8'h20, 1'b0, 8'h02};
      tab[8]  = '{1, 8'h22, 8'h21, 1'b1, 8'h1E};
      tab[9]  = '{2, 8'h33, 8'h30, 1'b0, 8'h03};
      tab[10] = '{2, 8'h33, 8'h31, 1'b1, 8'h61};
      tab[11] = '{3, 8'h44, 8'h40, 1'b0, 8'h04};
      tab[12] = '{3, 8'h44, 8'h41, 1'b1, 8'h20};

      repeat (3) @(negedge clk);
      check("reset_req_ready", 32'(bus.req_ready), 32'd0);
      check("reset_resp", 32'({bus.resp_valid, bus.resp_ch, bus.resp_data, bus.resp_last, bus.busy}), 32'd0);
      check("reset_core", 32'({bus.core_new_msg, bus.core_key, bus.core_in_valid, bus.core_in}), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_core_quiet", 32'({bus.busy, bus.core_new_msg, bus.core_in_valid}), 32'd0);

      // Single channel, five bytes.
      base = rcnt; kb = kcnt;
      for (int i = 0; i < 5; i++) begin
         ch_key[tab[i].ch] = tab[i].key;
         push(tab[i].ch, tab[i].data, tab[i].last);
      end
      wait_resp(base + 5, "t1_timeout");
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t1_ch[%0d]", i),   32'(rlog[base+i].ch),   32'(tab[i].ch));
         check($sformatf("t1_data[%0d]", i), 32'(rlog[base+i].data), 32'(tab[i].exp));
         check($sformatf("t1_last[%0d]", i), 32'(rlog[base+i].last), 32'(tab[i].last));
      end
      check("t1_loads", 32'(kcnt - kb), 32'd1);
      check("t1_key", 32'(klog[kb]), 32'h2B);

      // All four channels at once from rr_ptr=0.
      do_reset();
      base = rcnt; kb = kcnt;
      for (int i = 5; i < 13; i++) begin
         ch_key[tab[i].ch] = tab[i].key;
         push(tab[i].ch, tab[i].data, tab[i].last);
      end
      wait_resp(base + 8, "t2_timeout");
      for (int i = 5; i < 13; i++) begin
         check($sformatf("t2_ch[%0d]", i),   32'(rlog[base+i-5].ch),   32'(tab[i].ch));
         check($sformatf("t2_data[%0d]", i), 32'(rlog[base+i-5].data), 32'(tab[i].exp));
         check($sformatf("t2_last[%0d]", i), 32'(rlog[base+i-5].last), 32'(tab[i].last));
      end
      check("t2_loads", 32'(kcnt - kb), 32'd4);
      for (int c = 0; c < 4; c++)
         check($sformatf("t2_key[%0d]", c), 32'(klog[kb+c]), 32'(8'h11 * (c + 1)));

      // ch2 finishes -> rr_ptr=3, so ch3 beats ch1.
      base = rcnt; kb = kcnt;
      ch_key[2] = 8'h77;
      push(2, 8'h5A, 1'b1);
      wait_resp(base + 1, "t3a_timeout");
      ch_key[1] = 8'h66; ch_key[3] = 8'h99;
      push(1, 8'h01, 1'b1);
      push(3, 8'h02, 1'b1);
      wait_resp(base + 3, "t3b_timeout");
      check("t3_ch2_data", 32'(rlog[base].data), 32'h2D);
      check("t3_first_ch", 32'(rlog[base+1].ch), 32'd3);
      check("t3_first_data", 32'(rlog[base+1].data), 32'(enc(8'h99, 0, 8'h02)));
      check("t3_second_ch", 32'(rlog[base+2].ch), 32'd1);
      check("t3_second_data", 32'(rlog[base+2].data), 32'(enc(8'h66, 0, 8'h01)));
      check("t3_keys", 32'({klog[kb], klog[kb+1], klog[kb+2]}), 32'h779966);

      // ch1 stalls mid-message; ch0 must not be served until ch1 finishes.
      do_reset();
      base = rcnt; kb = kcnt;
      ch_key[1] = 8'h3C;
      for (int i = 0; i < 5; i++) push(1, 8'hA0 + 8'(i), (i == 4));
      wait_resp(base + 2, "t4a_timeout");
      hold[1] = 1'b1;
      ch_key[0] = 8'h5D;
      push(0, 8'h55, 1'b1);
      repeat (4) @(negedge clk);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.req_ready[0]) bad++;
      end
      check("t4_ch0_ready_during_hold", 32'(bad), 32'd0);
      check("t4_ch1_still_ready", 32'(bus.req_ready), 32'b0010);
      check("t4_loads_during_hold", 32'(kcnt - kb), 32'd1);
      hold[1] = 1'b0;
      wait_resp(base + 6, "t4b_timeout");
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t4_ch[%0d]", i), 32'(rlog[base+i].ch), 32'd1);
         check($sformatf("t4_data[%0d]", i), 32'(rlog[base+i].data), 32'(enc(8'h3C, i, 8'hA0 + 8'(i))));
      end
      check("t4_ch0_after", 32'({rlog[base+5].ch, rlog[base+5].data}), 32'({2'd0, enc(8'h5D, 0, 8'h55)}));
      check("t4_loads", 32'(kcnt - kb), 32'd2);
      check("t4_key2", 32'(klog[kb+1]), 32'h5D);

      // Encrypt then replay ciphertext with same key.
      do_reset();
      pt[0] = 8'h00; pt[1] = 8'h3C; pt[2] = 8'h7E; pt[3] = 8'hC3; pt[4] = 8'hFF;
      base = rcnt;
      ch_key[2] = 8'hA5;
      for (int i = 0; i < 5; i++) push(2, pt[i], (i == 4));
      wait_resp(base + 5, "t5a_timeout");
      for (int i = 0; i < 5; i++) begin
         ct[i] = rlog[base+i].data;
         check($sformatf("t5_ct[%0d]", i), 32'(ct[i]), 32'(enc(8'hA5, i, pt[i])));
      end
      base = rcnt;
      for (int i = 0; i < 5; i++) push(2, ct[i], (i == 4));
      wait_resp(base + 5, "t5b_timeout");
      for (int i = 0; i < 5; i++)
         check($sformatf("t5_roundtrip[%0d]", i), 32'(rlog[base+i].data), 32'(pt[i]));

      // Reset in WAIT: outputs drop immediately, byte discarded, restart at ch0.
      do_reset();
      ch_key[2] = 8'h10;
      for (int i = 0; i < 3; i++) push(2, 8'h70 + 8'(i), (i == 2));
      bad = 0;
      while (!bus.core_in_valid && bad < 200) begin
         @(negedge clk);
         bad++;
      end
      check("t6_reach_pend", 32'(bus.core_in_valid), 32'd1);
      @(negedge clk);
      base = rcnt; kb = kcnt;
      rst_n = 1'b0;
      #1;
      check("t6_async_ready", 32'(bus.req_ready), 32'd0);
      check("t6_async_resp", 32'({bus.resp_valid, bus.resp_ch, bus.resp_data, bus.resp_last, bus.busy}), 32'd0);
      check("t6_async_core", 32'({bus.core_new_msg, bus.core_key, bus.core_in_valid, bus.core_in}), 32'd0);
      flush_release();
      repeat (4) @(negedge clk);
      check("t6_no_resp", 32'(rcnt - base), 32'd0);
      check("t6_no_load", 32'(kcnt - kb), 32'd0);
      ch_key[0] = 8'h10; ch_key[3] = 8'hC8;
      push(3, 8'h0F, 1'b1);
      push(0, 8'hF0, 1'b1);
      wait_resp(base + 2, "t6_timeout");
      check("t6_first_key", 32'(klog[kb]), 32'h10);
      check("t6_first", 32'({rlog[base].ch, rlog[base].data}), 32'({2'd0, 8'hE0}));
      check("t6_second", 32'({rlog[base+1].ch, rlog[base+1].data}), 32'({2'd3, enc(8'hC8, 0, 8'h0F)}));

      check("ready_onehot", 32'(onehot_err), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
